// File: rtl/kbd_pkg.sv
// Shared constants for the i8042-style keyboard controller: port addresses,
// controller command codes, status bit positions and the command FSM states.
package kbd_pkg;

    localparam logic [15:0] PORT_DATA = 16'h0060;
    localparam logic [15:0] PORT_CMD  = 16'h0064;

    localparam logic [7:0] CMD_RDCB  = 8'h20;
    localparam logic [7:0] CMD_WRCB  = 8'h60;
    localparam logic [7:0] CMD_DIS   = 8'hAD;
    localparam logic [7:0] CMD_EN    = 8'hAE;
    localparam logic [7:0] CMD_FLUSH = 8'hF0;

    localparam int ST_OBF  = 0;
    localparam int ST_KDIS = 4;
    localparam int ST_OVF  = 7;

    typedef enum logic {
        IDLE = 1'b0,
        WCMD = 1'b1
    } kbd_state_t;

    function automatic logic [7:0] status_byte(input logic ovf, input logic kdis, input logic obf);
        logic [7:0] s;
        s          = 8'h00;
        s[ST_OVF]  = ovf;
        s[ST_KDIS] = kdis;
        s[ST_OBF]  = obf;
        return s;
    endfunction

endpackage

// File: rtl/kbd_fifo.sv
// Scan-code FIFO. A pop frees its slot in the same cycle, so a push into a
// full FIFO alongside a pop is accepted. Flush overrides both.
module kbd_fifo #(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [7:0]    din,
    output logic [7:0]    dout,
    output logic          empty,
    output logic          full,
    output logic [AW:0]   count
);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [7:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_pop;
    logic          w_push;

    assign empty  = (r_count == '0);
    assign full   = (r_count == FULL_CNT);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_pop  = pop && !empty;
    assign w_push = push && (!full || w_pop);

    always_ff @(posedge clock) begin
        if (!reset && !flush && w_push)
            r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {{AW{1'b0}}, w_push} - {{AW{1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/kbd_ctrl.sv
// Keyboard controller: buffers PS/2 scan codes, decodes ports 060h/064h,
// runs the controller command FSM and drives the level IRQ1 line.
module kbd_ctrl
    import kbd_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        kb_done,
    input  logic [7:0]  kb_data,
    input  logic [15:0] pa,
    input  logic        pr,
    input  logic        pw,
    input  logic [7:0]  pout,
    output logic [7:0]  pin,
    output logic        irq
);
    logic        w_rd_data, w_rd_stat, w_wr_data, w_wr_cmd;
    logic        w_push, w_pop, w_flush, w_push_acc, w_ovf_set;
    logic        w_empty, w_full;
    logic [7:0]  w_dout;
    logic [AW:0] w_count, w_count_next;
    logic [7:0]  w_cmd_next;
    logic        w_resp_valid_next;

    kbd_state_t  r_state;
    logic [7:0]  r_cmd_byte, r_resp, r_last;
    logic        r_resp_valid, r_overflow;

    assign w_rd_data  = pr && (pa == PORT_DATA);
    assign w_rd_stat  = pr && (pa == PORT_CMD);
    assign w_wr_data  = pw && (pa == PORT_DATA);
    assign w_wr_cmd   = pw && (pa == PORT_CMD);
    assign w_push     = kb_done && !r_cmd_byte[ST_KDIS];
    assign w_flush    = w_wr_cmd && (pout == CMD_FLUSH);
    assign w_pop      = w_rd_data && !r_resp_valid && !w_empty;
    assign w_push_acc = w_push && (!w_full || w_pop);
    assign w_ovf_set  = w_push && !w_push_acc && !w_flush;
    // Next FIFO occupancy, so irq can be registered from next-state values.
    assign w_count_next = w_flush ? '0
                        : w_count + {{AW{1'b0}}, w_push_acc} - {{AW{1'b0}}, w_pop};

    kbd_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (w_push),
        .pop   (w_pop),
        .flush (w_flush),
        .din   (kb_data),
        .dout  (w_dout),
        .empty (w_empty),
        .full  (w_full),
        .count (w_count)
    );

    always_comb begin
        w_cmd_next        = r_cmd_byte;
        w_resp_valid_next = r_resp_valid;
        if (w_rd_data)
            w_resp_valid_next = 1'b0;
        if (w_wr_cmd) begin
            case (pout)
                CMD_DIS:  w_cmd_next[ST_KDIS] = 1'b1;
                CMD_EN:   w_cmd_next[ST_KDIS] = 1'b0;
                CMD_RDCB: w_resp_valid_next   = 1'b1;
                default:  ;
            endcase
        end else if (w_wr_data && r_state == WCMD) begin
            w_cmd_next = pout;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_cmd_byte   <= 8'h01;
            r_resp       <= 8'h00;
            r_resp_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_last       <= 8'h00;
            pin          <= 8'h00;
            irq          <= 1'b0;
        end else begin
            r_cmd_byte   <= w_cmd_next;
            r_resp_valid <= w_resp_valid_next;
            if (w_wr_cmd && pout == CMD_RDCB)
                r_resp <= r_cmd_byte;

            if (w_wr_cmd)
                r_state <= (pout == CMD_WRCB) ? WCMD : IDLE;
            else if (w_wr_data && r_state == WCMD)
                r_state <= IDLE;

            // A same-cycle overflow outlives the clearing status read.
            if (w_flush)
                r_overflow <= 1'b0;
            else if (w_ovf_set)
                r_overflow <= 1'b1;
            else if (w_rd_stat)
                r_overflow <= 1'b0;

            if (w_rd_data) begin
                if (r_resp_valid) begin
                    pin <= r_resp;
                end else if (!w_empty) begin
                    pin    <= w_dout;
                    r_last <= w_dout;
                end else begin
                    pin <= r_last;
                end
            end else if (w_rd_stat) begin
                pin <= status_byte(r_overflow, r_cmd_byte[ST_KDIS], r_resp_valid || !w_empty);
            end

            irq <= w_cmd_next[0] && (w_resp_valid_next || (w_count_next != '0));
        end
    end

endmodule
